// File: rtl/pie_pkg.sv
// Shared definitions for the PIE reader transmitter: FSM states, default
// tick counts and derived segment lengths.
package pie_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_DELIM,
        ST_DATA0,
        ST_RTCAL,
        ST_TRCAL,
        ST_DATA
    } state_t;

    localparam int TARI_TICKS_DEF  = 4;
    localparam int DATA1_TICKS_DEF = 7;
    localparam int PW_TICKS_DEF    = 2;
    localparam int DELIM_TICKS_DEF = 8;
    localparam int TRCAL_TICKS_DEF = 24;

    // RTcal spans one data-0 plus one data-1 symbol.
    function automatic int rtcal_ticks(input int tari, input int data1);
        return tari + data1;
    endfunction

    // TRcal is the longest symbol, so it and the delimiter bound the counter.
    function automatic int seg_width(input int trcal, input int delim);
        int m;
        m = (trcal > delim) ? trcal : delim;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/pie_seg_timer.sv
// Tick-qualified segment counter: flags the falling-edge tick of a symbol's
// trailing low pulse and the final tick of the segment.
module pie_seg_timer #(
    parameter int CW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          tick,
    input  logic          clear,
    input  logic [CW-1:0] len,
    input  logic [CW-1:0] pw,
    output logic          fall,
    output logic          seg_end
);

    logic [CW-1:0] cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (clear) begin
            cnt_reg <= '0;
        end else if (tick) begin
            cnt_reg <= cnt_reg + CW'(1);
        end
    end

    assign fall    = tick && (cnt_reg == len - pw - CW'(1));
    assign seg_end = tick && (cnt_reg == len - CW'(1));

endmodule

// File: rtl/pie_encoder.sv
// PIE frame transmitter: delimiter, data-0, RTcal, optional TRcal, then one
// PIE symbol per command bit taken over a valid/ready handshake.
module pie_encoder
    import pie_pkg::*;
#(
    parameter int TARI_TICKS  = TARI_TICKS_DEF,
    parameter int DATA1_TICKS = DATA1_TICKS_DEF,
    parameter int PW_TICKS    = PW_TICKS_DEF,
    parameter int DELIM_TICKS = DELIM_TICKS_DEF,
    parameter int TRCAL_TICKS = TRCAL_TICKS_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic start,
    input  logic preamble,
    input  logic bit_data,
    input  logic bit_last,
    input  logic bit_valid,
    output logic bit_ready,
    output logic tx_out,
    output logic busy,
    output logic done,
    output logic underrun
);

    localparam int CW = seg_width(TRCAL_TICKS, DELIM_TICKS);
    localparam logic [CW-1:0] L_TARI  = CW'(TARI_TICKS);
    localparam logic [CW-1:0] L_DATA1 = CW'(DATA1_TICKS);
    localparam logic [CW-1:0] L_RTCAL = CW'(rtcal_ticks(TARI_TICKS, DATA1_TICKS));
    localparam logic [CW-1:0] L_TRCAL = CW'(TRCAL_TICKS);
    localparam logic [CW-1:0] L_DELIM = CW'(DELIM_TICKS);
    localparam logic [CW-1:0] L_PW    = CW'(PW_TICKS);

    state_t state_reg, state_next;
    logic tx_reg, tx_next;
    logic done_reg, done_next;
    logic underrun_reg, underrun_next;
    logic pre_reg, pre_next;
    logic hold_valid_reg, hold_valid_next;
    logic hold_data_reg, hold_data_next;
    logic hold_last_reg, hold_last_next;
    logic cur_data_reg, cur_data_next;
    logic cur_last_reg, cur_last_next;
    logic last_acc_reg, last_acc_next;

    logic          seg_clear;
    logic          data_entry;
    logic          accept;
    logic          fall;
    logic          seg_end;
    logic [CW-1:0] seg_len;

    assign busy      = (state_reg != ST_IDLE);
    assign bit_ready = busy && !hold_valid_reg && !last_acc_reg;
    assign accept    = bit_valid && bit_ready;
    assign tx_out    = tx_reg;
    assign done      = done_reg;
    assign underrun  = underrun_reg;

    always_comb begin
        case (state_reg)
            ST_DELIM: seg_len = L_DELIM;
            ST_RTCAL: seg_len = L_RTCAL;
            ST_TRCAL: seg_len = L_TRCAL;
            ST_DATA:  seg_len = cur_data_reg ? L_DATA1 : L_TARI;
            default:  seg_len = L_TARI;
        endcase
    end

    pie_seg_timer #(
        .CW(CW)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .tick    (tick),
        .clear   (seg_clear),
        .len     (seg_len),
        .pw      (L_PW),
        .fall    (fall),
        .seg_end (seg_end)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            tx_reg         <= 1'b1;
            done_reg       <= 1'b0;
            underrun_reg   <= 1'b0;
            pre_reg        <= 1'b0;
            hold_valid_reg <= 1'b0;
            hold_data_reg  <= 1'b0;
            hold_last_reg  <= 1'b0;
            cur_data_reg   <= 1'b0;
            cur_last_reg   <= 1'b0;
            last_acc_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            tx_reg         <= tx_next;
            done_reg       <= done_next;
            underrun_reg   <= underrun_next;
            pre_reg        <= pre_next;
            hold_valid_reg <= hold_valid_next;
            hold_data_reg  <= hold_data_next;
            hold_last_reg  <= hold_last_next;
            cur_data_reg   <= cur_data_next;
            cur_last_reg   <= cur_last_next;
            last_acc_reg   <= last_acc_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        tx_next         = tx_reg;
        done_next       = 1'b0;
        underrun_next   = 1'b0;
        pre_next        = pre_reg;
        hold_valid_next = hold_valid_reg;
        hold_data_next  = hold_data_reg;
        hold_last_next  = hold_last_reg;
        cur_data_next   = cur_data_reg;
        cur_last_next   = cur_last_reg;
        last_acc_next   = last_acc_reg;
        seg_clear       = (state_reg == ST_IDLE) || (state_reg == ST_ARM);
        data_entry      = 1'b0;

        if (accept) begin
            hold_valid_next = 1'b1;
            hold_data_next  = bit_data;
            hold_last_next  = bit_last;
            last_acc_next   = bit_last;
        end

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    pre_next   = preamble;
                    state_next = ST_ARM;
                end
            end
            ST_ARM: begin
                if (tick) begin
                    state_next = ST_DELIM;
                    tx_next    = 1'b0;
                end
            end
            ST_DELIM: begin
                if (seg_end) begin
                    state_next = ST_DATA0;
                    tx_next    = 1'b1;
                    seg_clear  = 1'b1;
                end
            end
            ST_DATA0: begin
                if (fall) tx_next = 1'b0;
                if (seg_end) begin
                    state_next = ST_RTCAL;
                    tx_next    = 1'b1;
                    seg_clear  = 1'b1;
                end
            end
            ST_RTCAL: begin
                if (fall) tx_next = 1'b0;
                if (seg_end) begin
                    if (pre_reg) begin
                        state_next = ST_TRCAL;
                        tx_next    = 1'b1;
                        seg_clear  = 1'b1;
                    end else begin
                        data_entry = 1'b1;
                    end
                end
            end
            ST_TRCAL: begin
                if (fall) tx_next = 1'b0;
                if (seg_end) data_entry = 1'b1;
            end
            ST_DATA: begin
                if (fall) tx_next = 1'b0;
                if (seg_end) begin
                    if (cur_last_reg) begin
                        state_next      = ST_IDLE;
                        tx_next         = 1'b1;
                        done_next       = 1'b1;
                        hold_valid_next = 1'b0;
                        last_acc_next   = 1'b0;
                    end else begin
                        data_entry = 1'b1;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase

        // A bit arriving on the entry tick with the holding register empty is
        // consumed directly rather than parked.
        if (data_entry) begin
            tx_next   = 1'b1;
            seg_clear = 1'b1;
            if (hold_valid_reg) begin
                cur_data_next   = hold_data_reg;
                cur_last_next   = hold_last_reg;
                hold_valid_next = 1'b0;
                state_next      = ST_DATA;
            end else if (accept) begin
                cur_data_next   = bit_data;
                cur_last_next   = bit_last;
                hold_valid_next = 1'b0;
                state_next      = ST_DATA;
            end else begin
                underrun_next   = 1'b1;
                hold_valid_next = 1'b0;
                last_acc_next   = 1'b0;
                state_next      = ST_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_pie_encoder.sv
// Directed bench for pie_encoder: frame timing, preamble, underrun, reset,
// start handling and the bypass path.
module tb_pie_encoder;

    logic clk = 1'b0;
    logic rst_n, tick, start, preamble, bit_data, bit_last, bit_valid;
    logic bit_ready, tx_out, busy, done, underrun;

    int total = 0;
    int bad = 0;

    logic lvl [0:127];
    int   done_at, under_at, n_done, n_under, n_both;
    logic bits [0:3];
    int   n_bits, bit_idx;
    logic feed_en;
    int   bypass_k, start_k1, start_k2;

    int R_FS  [12] = '{8, 2, 2, 9, 2, 2, 2, 5, 2, 0, 0, 0};
    int R_PRE [12] = '{8, 2, 2, 9, 2, 22, 2, 2, 2, 5, 2, 0};
    int R_BYP [12] = '{8, 2, 2, 9, 2, 5, 2, 0, 0, 0, 0, 0};

    always #5 clk = ~clk;

    pie_encoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick      (tick),
        .start     (start),
        .preamble  (preamble),
        .bit_data  (bit_data),
        .bit_last  (bit_last),
        .bit_valid (bit_valid),
        .bit_ready (bit_ready),
        .tx_out    (tx_out),
        .busy      (busy),
        .done      (done),
        .underrun  (underrun)
    );

    // Expected level after tick k for alternating runs starting low; CW after.
    function automatic logic exp_level(input int runs [12], input int k);
        int acc;
        logic lv;
        acc = 0;
        lv  = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (runs[i] == 0) break;
            if (k < acc + runs[i]) return lv;
            acc += runs[i];
            lv = ~lv;
        end
        return 1'b1;
    endfunction

    task automatic step(input logic t);
        logic acc;
        tick      = t;
        bit_valid = feed_en && (bit_idx < n_bits);
        bit_data  = (bit_idx < n_bits) ? bits[bit_idx] : 1'b0;
        bit_last  = (bit_idx == n_bits - 1);
        #1;
        acc = bit_valid && bit_ready;
        @(posedge clk);
        #1;
        if (acc) bit_idx++;
        if (done) n_done++;
        if (underrun) n_under++;
        if (done && underrun) n_both++;
    endtask

    task automatic setup(input logic b0, input logic b1, input int nb, input logic fe);
        bits[0] = b0; bits[1] = b1; bits[2] = 1'b0; bits[3] = 1'b0;
        n_bits = nb; bit_idx = 0; feed_en = fe;
        done_at = -1; under_at = -1; n_done = 0; n_under = 0; n_both = 0;
        bypass_k = -1; start_k1 = -1; start_k2 = -1;
        for (int i = 0; i < 128; i++) lvl[i] = 1'bx;
    endtask

    task automatic launch(input logic pre, input logic with_tick);
        start = 1'b1;
        preamble = pre;
        step(with_tick);
        start = 1'b0;
        step(1'b0);
    endtask

    task automatic run_ticks(input int max_ticks);
        for (int k = 0; k < max_ticks; k++) begin
            if (bypass_k >= 0) feed_en = (k == bypass_k);
            start = (k == start_k1) || (k == start_k2);
            if (start) preamble = 1'b1;
            step(1'b1);
            start = 1'b0;
            lvl[k] = tx_out;
            if (done && done_at < 0) done_at = k;
            if (underrun && under_at < 0) under_at = k;
            if (bypass_k >= 0) feed_en = 1'b0;
            if (done || underrun) break;
            step(1'b0);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; tick = 1'b0; start = 1'b0; preamble = 1'b0;
        bit_data = 1'b0; bit_last = 1'b0; bit_valid = 1'b0; feed_en = 1'b0;
        n_bits = 0; bit_idx = 0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (tx_out !== 1'b1)    begin bad++; $display("FAIL reset_tx got=%b want=1", tx_out); end
        total++; if (busy !== 1'b0)      begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (bit_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", bit_ready); end
        total++; if (done !== 1'b0)      begin bad++; $display("FAIL reset_done got=%b want=0", done); end
        total++; if (underrun !== 1'b0)  begin bad++; $display("FAIL reset_underrun got=%b want=0", underrun); end
        rst_n = 1'b1;
        step(1'b0);
        $display("reset: tx=%b busy=%b ready=%b", tx_out, busy, bit_ready);
    endtask

    task automatic test_frame_sync;
        setup(1'b0, 1'b1, 2, 1'b1);
        launch(1'b0, 1'b0);
        run_ticks(80);
        step(1'b0);
        for (int k = 0; k <= 34; k++) begin
            total++;
            if (lvl[k] !== exp_level(R_FS, k)) begin
                bad++; $display("FAIL fs_level k=%0d got=%b want=%b", k, lvl[k], exp_level(R_FS, k));
            end
        end
        total++; if (done_at !== 34) begin bad++; $display("FAIL fs_done_tick got=%0d want=34", done_at); end
        total++; if (n_done !== 1)   begin bad++; $display("FAIL fs_done_count got=%0d want=1", n_done); end
        total++; if (n_under !== 0)  begin bad++; $display("FAIL fs_underrun got=%0d want=0", n_under); end
        total++; if (busy !== 1'b0)  begin bad++; $display("FAIL fs_busy_after got=%b want=0", busy); end
        $display("frame_sync: done_at=%0d bits_taken=%0d", done_at, bit_idx);
    endtask

    task automatic test_preamble;
        setup(1'b0, 1'b1, 2, 1'b1);
        launch(1'b1, 1'b0);
        run_ticks(80);
        step(1'b0);
        for (int k = 0; k <= 58; k++) begin
            total++;
            if (lvl[k] !== exp_level(R_PRE, k)) begin
                bad++; $display("FAIL pre_level k=%0d got=%b want=%b", k, lvl[k], exp_level(R_PRE, k));
            end
        end
        total++; if (done_at !== 58) begin bad++; $display("FAIL pre_done_tick got=%0d want=58", done_at); end
        total++; if (n_under !== 0)  begin bad++; $display("FAIL pre_underrun got=%0d want=0", n_under); end
        $display("preamble: done_at=%0d", done_at);
    endtask

    task automatic test_underrun;
        setup(1'b0, 1'b0, 1, 1'b0);
        launch(1'b0, 1'b0);
        run_ticks(80);
        for (int k = 0; k <= 23; k++) begin
            total++;
            if (lvl[k] !== exp_level(R_FS, k)) begin
                bad++; $display("FAIL ur_level k=%0d got=%b want=%b", k, lvl[k], exp_level(R_FS, k));
            end
        end
        total++; if (under_at !== 23) begin bad++; $display("FAIL ur_tick got=%0d want=23", under_at); end
        total++; if (tx_out !== 1'b1) begin bad++; $display("FAIL ur_tx got=%b want=1", tx_out); end
        step(1'b0);
        total++; if (busy !== 1'b0)   begin bad++; $display("FAIL ur_busy got=%b want=0", busy); end
        total++; if (underrun !== 1'b0) begin bad++; $display("FAIL ur_pulse_width got=%b want=0", underrun); end
        repeat (5) begin step(1'b1); step(1'b0); end
        total++; if (n_done !== 0)    begin bad++; $display("FAIL ur_done_seen got=%0d want=0", n_done); end
        total++; if (n_under !== 1)   begin bad++; $display("FAIL ur_count got=%0d want=1", n_under); end
        total++; if (n_both !== 0)    begin bad++; $display("FAIL ur_both got=%0d want=0", n_both); end
        $display("underrun: under_at=%0d busy=%b", under_at, busy);
    endtask

    task automatic test_reset_mid;
        setup(1'b0, 1'b1, 2, 1'b1);
        launch(1'b0, 1'b0);
        run_ticks(22);
        total++; if (lvl[21] !== 1'b0) begin bad++; $display("FAIL rm_low_before got=%b want=0", lvl[21]); end
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (tx_out !== 1'b1) begin bad++; $display("FAIL rm_tx_async got=%b want=1", tx_out); end
        total++; if (busy !== 1'b0)   begin bad++; $display("FAIL rm_busy_async got=%b want=0", busy); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        step(1'b0);
        setup(1'b0, 1'b1, 2, 1'b1);
        launch(1'b0, 1'b0);
        run_ticks(80);
        for (int k = 0; k <= 34; k++) begin
            total++;
            if (lvl[k] !== exp_level(R_FS, k)) begin
                bad++; $display("FAIL rm_level k=%0d got=%b want=%b", k, lvl[k], exp_level(R_FS, k));
            end
        end
        total++; if (done_at !== 34) begin bad++; $display("FAIL rm_done_tick got=%0d want=34", done_at); end
        step(1'b0);
        $display("reset_mid: refire done_at=%0d", done_at);
    endtask

    task automatic test_start_timing;
        setup(1'b0, 1'b1, 2, 1'b1);
        start_k1 = 5;
        start_k2 = 34;
        launch(1'b0, 1'b1);
        run_ticks(80);
        step(1'b0);
        for (int k = 0; k <= 34; k++) begin
            total++;
            if (lvl[k] !== exp_level(R_FS, k)) begin
                bad++; $display("FAIL st_level k=%0d got=%b want=%b", k, lvl[k], exp_level(R_FS, k));
            end
        end
        total++; if (done_at !== 34) begin bad++; $display("FAIL st_done_tick got=%0d want=34", done_at); end
        total++; if (busy !== 1'b0)  begin bad++; $display("FAIL st_busy_after got=%b want=0", busy); end
        $display("start_timing: done_at=%0d busy=%b", done_at, busy);
    endtask

    task automatic test_bypass;
        setup(1'b1, 1'b0, 1, 1'b0);
        bypass_k = 23;
        launch(1'b0, 1'b0);
        run_ticks(80);
        step(1'b0);
        for (int k = 0; k <= 30; k++) begin
            total++;
            if (lvl[k] !== exp_level(R_BYP, k)) begin
                bad++; $display("FAIL by_level k=%0d got=%b want=%b", k, lvl[k], exp_level(R_BYP, k));
            end
        end
        total++; if (done_at !== 30) begin bad++; $display("FAIL by_done_tick got=%0d want=30", done_at); end
        total++; if (n_under !== 0)  begin bad++; $display("FAIL by_underrun got=%0d want=0", n_under); end
        total++; if (bit_idx !== 1)  begin bad++; $display("FAIL by_bits_taken got=%0d want=1", bit_idx); end
        $display("bypass: done_at=%0d", done_at);
    endtask

    initial begin
        test_reset;
        test_frame_sync;
        test_preamble;
        test_underrun;
        test_reset_mid;
        test_start_timing;
        test_bypass;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pie_encoder.md
# pie_encoder

Reader-to-tag Pulse-Interval-Encoding (PIE) transmitter for the RFID reader TX path. It sits directly downstream of the tick strobe generator and consumes its single-cycle strobe as the symbol time base (one tick = Tari/4 at defaults). It frames a command as delimiter, data-0, RTcal, optional TRcal (preamble) and PIE data symbols, and takes command bits over a valid/ready handshake. It drives the baseband modulation level to the DAC/modulator stage.

## Interface
- TARI_TICKS, 4: ticks per data-0 symbol (1 Tari)
- DATA1_TICKS, 7: ticks per data-1 symbol; legal TARI_TICKS < DATA1_TICKS <= 2*TARI_TICKS
- PW_TICKS, 2: low-pulse width at the end of every symbol; legal 1 <= PW_TICKS < TARI_TICKS
- DELIM_TICKS, 8: delimiter low time
- TRCAL_TICKS, 24: TRcal length; legal TRCAL_TICKS > RTcal (= TARI_TICKS + DATA1_TICKS)
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- tick  in  1  single-cycle time-base strobe
- start  in  1  frame request pulse; honoured only in IDLE
- preamble  in  1  sampled with start: 1 = preamble (with TRcal), 0 = frame-sync
- bit_data  in  1  command bit
- bit_last  in  1  marks final bit of the frame
- bit_valid  in  1  bit_data/bit_last valid
- bit_ready  out  1  encoder accepts a bit this cycle
- tx_out  out  1  modulation level: 1 = CW, 0 = attenuated
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse after the final symbol completes
- underrun  out  1  one-cycle pulse when a bit was required but none available

## Operation
- States: IDLE, ARM, DELIM, DATA0, RTCAL, TRCAL, DATA.
- Reset (async): state IDLE, tx_out=1, bit_ready=0, busy=0, done=0, underrun=0, holding register empty, counter 0.
- IDLE + start: latch preamble, go ARM. start in any other state ignored.
- All segment progress happens only on cycles with tick=1. A segment of length L runs counter 0..L-1.
- Symbols (DATA0, RTCAL, TRCAL, DATA): tx_out=1 at entry; tx_out<=0 on the tick where counter==L-PW_TICKS-1; segment ends on the tick where counter==L-1.
- DELIM: tx_out=0 for whole segment.
- Sequence: ARM -(tick)-> DELIM -> DATA0 -> RTCAL (L=TARI_TICKS+DATA1_TICKS) -> TRCAL if preamble latched -> DATA.
- DATA: L = TARI_TICKS for bit 0, DATA1_TICKS for bit 1; each DATA entry consumes one bit.
- One-entry holding register. bit_ready = busy && holding empty && last bit not yet accepted. Bits may be accepted from ARM onward.
- Bypass: if holding empty at a DATA-entry tick and bit_valid&&bit_ready that cycle, the incoming bit is used directly.
- Underrun: DATA entry with no bit available -> tx_out<=1, underrun pulse, state IDLE, holding cleared.
- End of a DATA symbol whose bit had bit_last=1: tx_out<=1, done pulse, IDLE.

## Timing
- tx_out, done, underrun registered; change on the clk edge where tick is sampled high.
- start and tick in the same cycle in IDLE: that tick is not used; delimiter starts on the next tick.
- Each level lasts exactly its tick count × tick period; no glitch cycles between segments.
- done and underrun never assert together; start in the cycle of done is ignored (state not yet IDLE).
- rst_n assertion mid-frame forces tx_out=1 immediately (CW restored).

## Structure
- Shared package pie_pkg: state encoding, default tick constants, RTcal derivation.
- Sub-module pie_seg_timer: tick-qualified counter with load length L and PW, outputs fall (counter==L-PW-1) and seg_end (counter==L-1); width $clog2(max(TRCAL_TICKS, DELIM_TICKS)+1).

## Test plan
- Frame-sync, bits 0,1(last), defaults -> tx_out low 8, high 2 low 2, high 9 low 2, high 2 low 2, high 5 low 2 ticks; done on tick 34.
- Same with preamble=1 -> TRcal high 22 low 2 inserted after RTcal; done on tick 58.
- bit_valid withheld at first DATA entry -> underrun pulse, tx_out=1, busy=0, done never asserted.
- rst_n pulsed mid-RTcal low pulse -> tx_out=1 same cycle; next start produces full correct frame.
- start coincident with tick, and start while busy -> delimiter begins on following tick; busy-time start ignored.
- Bit presented only in the DATA-entry cycle (bypass) -> no underrun, correct symbol length.
